// File: rtl/demux_1x4_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with a 2-entry FIFO per lane.
// Routing by explicit sel or round-robin; beats aimed at a non-existent lane are counted and dropped.

module demux_1x4_lane #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              ready,
   output logic [DATA_W-1:0] dout,
   output logic              vld,
   output logic              full
);
   logic [DATA_W-1:0] head, tail;
   logic [1:0]        cnt;
   logic              pop;

   assign vld  = (cnt != 2'd0);
   assign full = (cnt == 2'd2);
   assign dout = head;
   assign pop  = vld && ready;

   // tail is kept at zero unless it holds a beat, so head reads zero once drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= 2'd0;
      end else begin
         if (pop) begin
            head <= (push && cnt == 2'd1) ? din : tail;
            tail <= '0;
         end else if (push) begin
            if (cnt == 2'd0) head <= din;
            else             tail <= din;
         end
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end
endmodule

module demux_1x4_stream #(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      rr_mode,
   output logic [NUM_OUT*DATA_W-1:0] out_data,
   output logic [NUM_OUT-1:0]        out_valid,
   input  logic [NUM_OUT-1:0]        out_ready,
   output logic [SEL_W-1:0]          rr_ptr,
   output logic [7:0]                drop_cnt
);
   logic [SEL_W-1:0]   tgt;
   logic               tgt_ok, tgt_full, accept;
   logic [NUM_OUT-1:0] full, push;

   assign tgt    = rr_mode ? rr_ptr : sel;
   assign tgt_ok = (int'(tgt) < NUM_OUT);

   // in_ready sees only registered lane state, never out_ready
   always_comb begin
      tgt_full = 1'b0;
      for (int i = 0; i < NUM_OUT; i++)
         if (int'(tgt) == i) tgt_full = full[i];
   end

   assign in_ready = !tgt_ok || !tgt_full;
   assign accept   = in_valid && in_ready;

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
      assign push[g] = accept && (tgt == SEL_W'(g));
      demux_1x4_lane #(.DATA_W(DATA_W)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .din   (in_data),
         .ready (out_ready[g]),
         .dout  (out_data[g*DATA_W +: DATA_W]),
         .vld   (out_valid[g]),
         .full  (full[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         drop_cnt <= 8'd0;
      end else begin
         if (accept && rr_mode)
            rr_ptr <= (rr_ptr == SEL_W'(NUM_OUT-1)) ? '0 : rr_ptr + SEL_W'(1);
         if (accept && !tgt_ok && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed + randomized bench for demux_1x4_stream, checked against a queue-based lane model.
// A second 3-lane instance covers the drop path.

module tb_demux_1x4_stream;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid, in_ready, rr_mode;
   logic [1:0]  sel, rr_ptr;
   logic [31:0] out_data;
   logic [3:0]  out_valid, out_ready;
   logic [7:0]  drop_cnt;

   logic [7:0]  d3_in_data;
   logic        d3_in_valid, d3_in_ready, d3_rr_mode;
   logic [1:0]  d3_sel, d3_rr_ptr;
   logic [23:0] d3_out_data;
   logic [2:0]  d3_out_valid, d3_out_ready;
   logic [7:0]  d3_drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq [4][$];
   int         mrr, mdrop;

   always #5 clk = ~clk;

   demux_1x4_stream #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .rr_mode(rr_mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .rr_ptr(rr_ptr), .drop_cnt(drop_cnt));

   demux_1x4_stream #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
      .sel(d3_sel), .rr_mode(d3_rr_mode), .out_data(d3_out_data), .out_valid(d3_out_valid),
      .out_ready(d3_out_ready), .rr_ptr(d3_rr_ptr), .drop_cnt(d3_drop_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lane(input int i);
      return out_data[i*8 +: 8];
   endfunction

   function automatic logic exp_ready();
      int t;
      t = rr_mode ? mrr : int'(sel);
      if (t >= 4) return 1'b1;
      return mq[t].size() < 2;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) mq[i].delete();
      mrr   = 0;
      mdrop = 0;
   endtask

   task automatic check_model();
      chk("m_in_ready", 32'(in_ready), 32'(exp_ready()));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("m_valid%0d", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
         if (mq[i].size() > 0) chk($sformatf("m_data%0d", i), 32'(lane(i)), 32'(mq[i][0]));
      end
      chk("m_rr_ptr", 32'(rr_ptr), 32'(mrr));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(mdrop));
   endtask

   // acceptance is decided on pre-edge occupancy, then lanes pop, then the beat is queued
   task automatic model_edge();
      int  t;
      logic acc;
      t   = rr_mode ? mrr : int'(sel);
      acc = in_valid && exp_ready();
      for (int i = 0; i < 4; i++)
         if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
      if (acc) begin
         if (t < 4) mq[t].push_back(in_data);
         else if (mdrop < 255) mdrop++;
         if (rr_mode) mrr = (mrr == 3) ? 0 : mrr + 1;
      end
   endtask

   task automatic step();
      #1;
      check_model();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_data = '0; in_valid = 1'b0; sel = '0; rr_mode = 1'b0; out_ready = '0;
      d3_in_data = '0; d3_in_valid = 1'b0; d3_sel = '0; d3_rr_mode = 1'b0; d3_out_ready = '0;
      model_clear();
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
      rst = 1'b0;

      // drop path on the 3-lane instance
      d3_out_ready = 3'b111; d3_sel = 2'd3; d3_in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         d3_in_data = 8'($urandom);
         #1;
         chk("drop_in_ready", 32'(d3_in_ready), 32'h1);
         chk("drop_out_valid", 32'(d3_out_valid), 32'h0);
         if (i == 100 || i == 254 || i == 255)
            chk($sformatf("drop_cnt_at%0d", i), 32'(d3_drop_cnt), 32'(i));
         @(posedge clk); @(negedge clk);
      end
      d3_in_valid = 1'b0;
      chk("drop_cnt_sat", 32'(d3_drop_cnt), 32'd255);

      // explicit routing
      out_ready = 4'hF; rr_mode = 1'b0; in_valid = 1'b1;
      sel = 2'd0; in_data = 8'h11; step();
      chk("x0_valid", 32'(out_valid), 32'b0001);
      chk("x0_data", 32'(lane(0)), 32'h11);
      sel = 2'd1; in_data = 8'h22; step();
      chk("x1_valid", 32'(out_valid), 32'b0010);
      chk("x1_data", 32'(lane(1)), 32'h22);
      sel = 2'd3; in_data = 8'h33; step();
      chk("x3_valid", 32'(out_valid), 32'b1000);
      chk("x3_data", 32'(lane(3)), 32'h33);
      in_valid = 1'b0; step();
      chk("x_idle", 32'(out_valid), 32'h0);

      // backpressure on lane 1
      out_ready = 4'b1101; in_valid = 1'b1; sel = 2'd1;
      in_data = 8'h01; step();
      in_data = 8'h02; step();
      in_data = 8'h03; #1;
      chk("bp_full_ready", 32'(in_ready), 32'h0);
      step();
      sel = 2'd0; in_data = 8'h04; step();
      chk("bp_other_lane", 32'(lane(0)), 32'h04);
      chk("bp_head01", 32'(lane(1)), 32'h01);
      sel = 2'd1; in_data = 8'h03; out_ready = 4'hF; step();
      chk("bp_head02", 32'(lane(1)), 32'h02);
      step();
      chk("bp_head03", 32'(lane(1)), 32'h03);
      in_valid = 1'b0; step();
      chk("bp_drained", 32'(out_valid), 32'h0);

      // round-robin
      rr_mode = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data = 8'(8'h10 + k);
         step();
         chk($sformatf("rr_valid%0d", k), 32'(out_valid), 32'(1 << (k % 4)));
         chk($sformatf("rr_data%0d", k), 32'(lane(k % 4)), 32'(8'h10 + k));
      end
      in_valid = 1'b0; #1;
      chk("rr_wrap", 32'(rr_ptr), 32'h0);
      step();

      // simultaneous push and pop on lane 0
      rr_mode = 1'b0; sel = 2'd0; in_valid = 1'b1;
      out_ready = 4'b1110; in_data = 8'h55; step();
      out_ready = 4'hF; in_data = 8'h66; step();
      chk("pp_valid", 32'(out_valid), 32'b0001);
      chk("pp_head", 32'(lane(0)), 32'h66);
      in_valid = 1'b0; step();
      chk("pp_empty", 32'(out_valid), 32'h0);

      // reset mid-operation with lane 2 full and rr_ptr moved
      rr_mode = 1'b1; in_valid = 1'b1; in_data = 8'h77; step();
      rr_mode = 1'b0; sel = 2'd2; out_ready = 4'h0;
      in_data = 8'hA5; step();
      in_data = 8'h3C; step();
      in_valid = 1'b0; #1;
      chk("mr_pre_valid", 32'(out_valid), 32'b0101);
      chk("mr_pre_rr", 32'(rr_ptr), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mr_out_valid", 32'(out_valid), 32'h0);
      chk("mr_out_data", out_data, 32'h0);
      chk("mr_in_ready", 32'(in_ready), 32'h1);
      chk("mr_rr_ptr", 32'(rr_ptr), 32'h0);
      chk("mr_drop3", 32'(d3_drop_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = 8'($urandom);
         sel       = 2'($urandom);
         out_ready = 4'($urandom);
         if ($urandom_range(15) == 0) rr_mode = ~rr_mode;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
